// File: rtl/key_press_emulator_pkg.sv
// Shared types and timing constants for the key press emulator.
// Holds the FSM state encoding and default hold/gap/debounce windows.
package key_press_emulator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } kp_state_e;

  localparam logic [21:0] KEY_HOLD_DEF = 22'd2_000_100;
  localparam logic [21:0] KEY_GAP_DEF  = 22'd2_000_100;
  localparam int          DEBOUNCE_WIN = 2_000_000;

endpackage

// File: rtl/key_press_emulator_sat_updown_cnt.sv
// Saturating up/down counter; ovf strobes when an increment hits max.
// Ports: clk, rst (sync, active-low), inc, dec, q, ovf.
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q,
  output logic         ovf
);

  logic [W-1:0] q_d;
  logic         at_max;

  assign at_max = &q;
  // Simultaneous inc and dec cancel, so only a lone inc can drop.
  assign ovf    = inc & ~dec & at_max;

  always_comb begin
    q_d = q;
    if (inc && !dec && !at_max) begin
      q_d = q + 1'b1;
    end else if (dec && !inc && (q != '0)) begin
      q_d = q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/key_press_emulator.sv
// Turns request pulses into timed key presses (HOLD high, GAP low).
// Ports: clk, rst, pulse_in, clr_ovf -> key_out, busy, pending, overflow.
module key_press_emulator
  import key_press_emulator_pkg::*;
#(
  parameter logic [21:0] HOLD   = KEY_HOLD_DEF,
  parameter logic [21:0] GAP    = KEY_GAP_DEF,
  parameter int          PEND_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              clr_ovf,
  output logic              key_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  kp_state_e   state_q, state_d;
  logic [21:0] cnt_q, cnt_d;
  logic        inc, dec, drop;
  logic        pend_nz;

  assign pend_nz = (pending != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 22'd1;
    inc     = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A live pulse is used directly; the queue is left untouched.
        if (pulse_in) begin
          state_d = PRESS;
        end else if (pend_nz) begin
          state_d = PRESS;
          dec     = 1'b1;
        end
      end
      PRESS: begin
        inc = pulse_in;
        if (cnt_q == HOLD - 22'd1) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        inc = pulse_in;
        if (cnt_q == GAP - 22'd1) begin
          cnt_d = '0;
          if (pend_nz) begin
            state_d = PRESS;
            dec     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      key_out  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_out <= (state_d == PRESS);
      // A new drop wins over a clear in the same cycle.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  sat_updown_cnt #(
    .W(PEND_W)
  ) u_pend (
    .clk(clk),
    .rst(rst),
    .inc(inc),
    .dec(dec),
    .q  (pending),
    .ovf(drop)
  );

  assign busy = (state_q != IDLE) | pend_nz;

endmodule

// File: tb/tb_key_press_emulator.sv
// Directed bench for key_press_emulator (HOLD=5, GAP=3, PEND_W=2).
// Cycle numbers count clock edges after reset release.
module tb_key_press_emulator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pulse_in = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       key_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  key_press_emulator #(
    .HOLD  (22'd5),
    .GAP   (22'd3),
    .PEND_W(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pulse_in(pulse_in),
    .clr_ovf (clr_ovf),
    .key_out (key_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic single_press(input int p);
    run_to(p);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    repeat (9) begin
      chk("sp_key", 32'(key_out), 32'(cyc >= p + 1 && cyc <= p + 5));
      chk("sp_busy", 32'(busy), 32'(cyc <= p + 8));
      chk("sp_pend", 32'(pending), 32'd0);
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [1:0] ep;

    // 1: reset overrides pulse_in
    rst      = 1'b0;
    pulse_in = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_key", 32'(key_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pend", 32'(pending), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
    end
    rst      = 1'b1;
    pulse_in = 1'b0;
    repeat (4) begin
      tick();
      chk("post_rst_key", 32'(key_out), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

    // 2: single press
    do_reset();
    single_press(10);

    // 3: three back-to-back requests
    do_reset();
    run_to(10);
    for (int c = 10; c <= 36; c++) begin
      pulse_in = (c >= 10 && c <= 12);
      tick();
      n = cyc;
      if (n <= 11) ep = 2'd0;
      else if (n == 12) ep = 2'd1;
      else if (n <= 18) ep = 2'd2;
      else if (n <= 26) ep = 2'd1;
      else ep = 2'd0;
      chk("q3_key", 32'(key_out),
          32'((n >= 11 && n <= 15) || (n >= 19 && n <= 23) ||
              (n >= 27 && n <= 31)));
      chk("q3_pend", 32'(pending), 32'(ep));
      chk("q3_busy", 32'(busy), 32'(n <= 34));
    end

    // 4: saturation, overflow set-wins, clear, replay
    do_reset();
    run_to(10);
    for (int c = 10; c <= 45; c++) begin
      pulse_in = (c >= 10 && c <= 16);
      clr_ovf  = (c == 15 || c == 17);
      tick();
      n = cyc;
      if (n <= 11) ep = 2'd0;
      else if (n == 12) ep = 2'd1;
      else if (n == 13) ep = 2'd2;
      else if (n <= 18) ep = 2'd3;
      else if (n <= 26) ep = 2'd2;
      else if (n <= 34) ep = 2'd1;
      else ep = 2'd0;
      chk("sat_key", 32'(key_out),
          32'((n >= 11 && n <= 15) || (n >= 19 && n <= 23) ||
              (n >= 27 && n <= 31) || (n >= 35 && n <= 39)));
      chk("sat_pend", 32'(pending), 32'(ep));
      chk("sat_ovf", 32'(overflow), 32'(n >= 15 && n <= 17));
      chk("sat_busy", 32'(busy), 32'(n <= 42));
    end
    clr_ovf  = 1'b0;
    pulse_in = 1'b0;

    // 5: reset mid-press discards the queue
    do_reset();
    run_to(10);
    pulse_in = 1'b1;
    repeat (3) tick();
    pulse_in = 1'b0;
    chk("mid_pend_pre", 32'(pending), 32'd2);
    chk("mid_key_pre", 32'(key_out), 32'd1);
    rst = 1'b0;
    tick();
    chk("mid_key", 32'(key_out), 32'd0);
    chk("mid_pend", 32'(pending), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ovf", 32'(overflow), 32'd0);
    rst = 1'b1;
    single_press(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
